cdc_req_ack_tx: RTL

- Source-domain controller for moving a multi-bit word into another clock domain with a four-phase req/ack handshake.
- Accepts a word from an upstream valid/ready interface and holds it stable on xfer_data.
- Sequences xfer_req against a returning xfer_ack, which is synchronised internally through a 2-flop stage.
- Provides a done pulse per completed transfer and an optional ack timeout.

---
 rtl/cdc_req_ack_tx.sv | 110 +++++++++++
 1 files changed

// File: rtl/cdc_req_ack_tx.sv
// Source side of a four-phase req/ack word crossing; word held on xfer_data from accept until next accept.
// in_ready only in IDLE with synchronised ack low; done/timeout are single-cycle pulses with no back-pressure.
module cdc_req_ack_tx #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack,
  output logic             done,
  output logic             timeout
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  state_t           state, state_d;
  logic             ack_meta, ack_s;
  logic             req_d, done_d, timeout_d;
  logic [WIDTH-1:0] data_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             timed_out, timed_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= xfer_ack;
      ack_s    <= ack_meta;
    end
  end

  // Never offer a new word while a stale ack is still visible.
  assign in_ready = (state == IDLE) && !ack_s;

  always_comb begin
    state_d     = state;
    req_d       = xfer_req;
    data_d      = xfer_data;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    cnt_d       = cnt;
    timed_out_d = timed_out;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d      = in_data;
          req_d       = 1'b1;
          cnt_d       = '0;
          timed_out_d = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // A returning ack wins over an expiring counter on the same cycle.
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_LOW;
        end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
          req_d       = 1'b0;
          timeout_d   = 1'b1;
          timed_out_d = 1'b1;
          state_d     = ACK_LOW;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt + CW'(1);
        end
      end
      ACK_LOW: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = !timed_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_d;
      xfer_req  <= req_d;
      xfer_data <= data_d;
      done      <= done_d;
      timeout   <= timeout_d;
      cnt       <= cnt_d;
      timed_out <= timed_out_d;
    end
  end

endmodule
